// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared pipeline package: hazard FSM encodings and MDU defaults
//
// Contents:
//   pipe_state_e             hazard controller state encoding (2 bits)
//   PIPE_MDU_CYCLES_DEFAULT  default EX-stage stall length for multiply/divide
//   PIPE_MDU_CNT_W           width of the MDU wait down-counter
//   PIPE_REG_W               register specifier width
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MDU_WAIT = 2'b01,
        ST_RSVD_2   = 2'b10,
        ST_RSVD_3   = 2'b11
    } pipe_state_e;

    localparam int unsigned PIPE_MDU_CYCLES_DEFAULT = 32;
    localparam int unsigned PIPE_MDU_CNT_W          = 6;
    localparam int unsigned PIPE_REG_W              = 5;

endpackage

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - 32-bit saturating event counter with enable
//
// Ports:
//   in_clk     clock, counts on posedge
//   in_rst     asynchronous active-high reset, clears the count
//   in_en      count this edge
//   out_count  current count, holds at all-ones
module pipe_sat_counter (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_en,
    output logic [31:0] out_count
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (in_en && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign out_count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use / multiply-divide hazard controller for a 5-stage pipeline
//
// Ports:
//   in_clk, in_rst            clock, asynchronous active-high reset
//   in_id_rs, in_id_rt        source register fields of the instruction in ID
//   in_id_use_rs, in_id_use_rt  ID instruction actually reads rs / rt
//   in_ex_load, in_ex_rd      EX instruction is a load, and its destination
//   in_branch                 taken branch/jump resolved in ID
//   in_mdu_start              multiply/divide enters EX
//   out_pc_stall              hold PC
//   out_if_id_stall           hold IF/ID
//   out_if_id_flush           zero IF/ID (branch), suppressed by a stall
//   out_id_ex_bubble          insert NOP into ID/EX
//   out_state                 current FSM state
//   out_stall_count           saturating count of stalled cycles since reset
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MDU_CYCLES = PIPE_MDU_CYCLES_DEFAULT
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic [4:0]  in_id_rs,
    input  logic [4:0]  in_id_rt,
    input  logic        in_id_use_rs,
    input  logic        in_id_use_rt,
    input  logic        in_ex_load,
    input  logic [4:0]  in_ex_rd,
    input  logic        in_branch,
    input  logic        in_mdu_start,
    output logic        out_pc_stall,
    output logic        out_if_id_stall,
    output logic        out_if_id_flush,
    output logic        out_id_ex_bubble,
    output logic [1:0]  out_state,
    output logic [31:0] out_stall_count
);

    // Loading MDU_CYCLES-1 and leaving on the edge where the counter is zero
    // yields exactly MDU_CYCLES cycles spent in MDU_WAIT.
    localparam logic [PIPE_MDU_CNT_W-1:0] MDU_LOAD = PIPE_MDU_CNT_W'(MDU_CYCLES - 1);

    pipe_state_e                state_q;
    logic [PIPE_MDU_CNT_W-1:0]  mdu_cnt_q;

    logic in_run;
    logic in_wait;
    logic rs_match;
    logic rt_match;
    logic load_hazard;
    logic stall;

    assign in_run   = (state_q == ST_RUN);
    assign in_wait  = (state_q == ST_MDU_WAIT);
    assign rs_match = in_id_use_rs && (in_id_rs == in_ex_rd);
    assign rt_match = in_id_use_rt && (in_id_rt == in_ex_rd);

    // $0 is hardwired zero, so a load "writing" it never creates a dependency.
    assign load_hazard = in_run && in_ex_load && (in_ex_rd != 5'd0) && (rs_match || rt_match);

    // Unused encodings assert nothing; they only last one cycle.
    assign stall            = in_wait || load_hazard;
    assign out_pc_stall     = stall;
    assign out_if_id_stall  = stall;
    assign out_id_ex_bubble = load_hazard;
    assign out_if_id_flush  = in_branch && !stall;
    assign out_state        = state_q;

    // A coincident load hazard only affects the outputs above; the MDU
    // start is still accepted from RUN.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q   <= ST_RUN;
            mdu_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (in_mdu_start) begin
                        state_q   <= ST_MDU_WAIT;
                        mdu_cnt_q <= MDU_LOAD;
                    end
                end
                ST_MDU_WAIT: begin
                    if (mdu_cnt_q == '0) begin
                        state_q <= ST_RUN;
                    end else begin
                        mdu_cnt_q <= mdu_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_RUN;
                    mdu_cnt_q <= '0;
                end
            endcase
        end
    end

    pipe_sat_counter u_stall_cnt (
        .in_clk    (in_clk),
        .in_rst    (in_rst),
        .in_en     (out_if_id_stall),
        .out_count (out_stall_count)
    );

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: MDU_CYCLES, 32, EX-stage stall length in cycles for a multiply/divide; legal range 1..63.
REQ-002 in_clk  input  1  the only clock; all state updates on posedge.
REQ-003 in_rst  input  1  asynchronous, active-high reset.
REQ-004 in_id_rs  input  5  rs field of the instruction in ID.
REQ-005 in_id_rt  input  5  rt field of the instruction in ID.
REQ-006 in_id_use_rs  input  1  ID instruction reads rs.
REQ-007 in_id_use_rt  input  1  ID instruction reads rt.
REQ-008 in_ex_load  input  1  the instruction in EX is a load.
REQ-009 in_ex_rd  input  5  destination register of the instruction in EX.
REQ-010 in_branch  input  1  taken branch/jump resolved in ID this cycle.
REQ-011 in_mdu_start  input  1  multiply/divide enters EX this cycle.
REQ-012 out_pc_stall  output  1  hold PC.
REQ-013 out_if_id_stall  output  1  drives the IF/ID register stall input.
REQ-014 out_if_id_flush  output  1  drives the IF/ID register branch (zeroing) input.
REQ-015 out_id_ex_bubble  output  1  load a NOP into ID/EX.
REQ-016 out_state  output  2  current FSM state encoding.
REQ-017 out_stall_count  output  32  total stalled cycles since reset.

Function
REQ-018 The FSM SHALL have states RUN=2'b00 and MDU_WAIT=2'b01; 2'b10 and 2'b11 SHALL be unused and SHALL recover to RUN on the next edge.
REQ-019 load_hazard SHALL be defined as RUN & in_ex_load & (in_ex_rd != 0) & ((in_id_use_rs & in_id_rs == in_ex_rd) | (in_id_use_rt & in_id_rt == in_ex_rd)), evaluated combinationally.
REQ-020 In RUN with load_hazard=1, out_pc_stall, out_if_id_stall and out_id_ex_bubble SHALL be 1 in the same cycle, and the FSM SHALL remain in RUN.
REQ-021 In RUN with in_mdu_start=1, the FSM SHALL enter MDU_WAIT on the next edge and load a 6-bit down-counter with MDU_CYCLES-1.
REQ-022 In MDU_WAIT, out_pc_stall and out_if_id_stall SHALL be 1, out_id_ex_bubble SHALL be 0, the counter SHALL decrement each cycle, and the FSM SHALL return to RUN on the edge where the counter equals 0, giving exactly MDU_CYCLES stall cycles.
REQ-023 in_mdu_start SHALL be ignored while in MDU_WAIT.
REQ-024 out_if_id_flush SHALL equal in_branch & ~out_if_id_stall, so a stall suppresses a flush in the same cycle.
REQ-025 A load-use hazard coinciding with in_mdu_start in RUN SHALL still stall that cycle, and SHALL still enter MDU_WAIT.
REQ-026 out_stall_count SHALL increment by 1 on every edge where out_if_id_stall=1, and SHALL saturate at 32'hFFFFFFFF.
REQ-027 All outputs other than out_state and out_stall_count SHALL be combinational from state, counter and inputs; there SHALL be no latches.

Reset
REQ-028 While in_rst=1, the FSM SHALL be in RUN, the down-counter SHALL be 0, and out_stall_count SHALL be 0; all stall, flush and bubble outputs then follow REQ-019..024 for RUN.
REQ-029 Reset asserted in MDU_WAIT SHALL abort the wait immediately (asynchronously), with no residual stall cycle after release.

Structure
REQ-030 The state encodings and the default MDU_CYCLES SHALL reside in a shared pipeline package, reused by the datapath top level.
REQ-031 The saturating counter SHALL be a sub-module named pipe_sat_counter (32-bit, enable, asynchronous active-high reset).

Verification
REQ-032 EX = lw to $5, ID reads rs=$5 -> one cycle with stall=1 and bubble=1, then RUN with stall=0; out_stall_count=1.
REQ-033 EX = lw to $0, ID reads $0 -> no stall; EX not a load with rd match -> no stall.
REQ-034 in_mdu_start pulse with MDU_CYCLES=32 -> exactly 32 consecutive cycles of out_if_id_stall=1 with bubble=0, then RUN; out_stall_count=32; a second in_mdu_start during the wait has no effect.
REQ-035 in_branch=1 in RUN with no hazard -> flush=1 that cycle; in_branch=1 together with load_hazard -> flush=0, stall=1.
REQ-036 in_rst asserted at wait cycle 10 -> out_state=00, all stalls=0, out_stall_count=0 immediately; after release, no stall.
REQ-037 Preload the counter near 32'hFFFFFFFF (force), then apply 3 stall cycles -> the counter holds at 32'hFFFFFFFF.
